issue_sched: RTL and testbench

- Issue scheduler between the instruction-decode and execute stages.
- Keeps a per-register pending-write count (scoreboard) and blocks issue on RAW hazards and on pending-count saturation.
- Produces the decode→exec handshake and the register-reservation bitmap.
- Provides a drain sequence used before pipeline flush or halt.

---
 rtl/issue_sched_pkg.sv | 24 ++
 rtl/issue_sched_if.sv | 45 ++++
 rtl/issue_sched_pend_cnt.sv | 48 ++++
 rtl/issue_sched.sv | 110 +++++++++++
 tb/tb_issue_sched.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/issue_sched_pkg.sv
//------------------------------------------------------------------------------
// Module   : venus_sched_pkg
// Desc     : Shared types and default sizes for the issue scheduler.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package venus_sched_pkg;

   localparam int NREG     = 4;
   localparam int IDX_W    = 2;
   localparam int MAX_PEND = 3;
   localparam int CNT_W    = 2;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2,
      ST_HOLD  = 2'd3
   } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/issue_sched_if.sv
//------------------------------------------------------------------------------
// Module   : issue_sched_if
// Desc     : Decode/exec/writeback/drain bundle of the issue scheduler.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface issue_sched_if
   import venus_sched_pkg::*;
#(
   parameter int NREG_P  = NREG,
   parameter int IDX_W_P = IDX_W
);
   logic               dec_valid;
   logic               dec_ready;
   logic               dec_rs_use;
   logic [IDX_W_P-1:0] dec_rs_idx;
   logic               dec_rt_use;
   logic [IDX_W_P-1:0] dec_rt_idx;
   logic               dec_rd_wr;
   logic [IDX_W_P-1:0] dec_rd_idx;
   logic               exec_valid;
   logic               exec_ready;
   logic               wb_valid;
   logic [IDX_W_P-1:0] wb_idx;
   logic               drain_req;
   logic               drain_done;
   logic [NREG_P-1:0]  reserved;
   logic               sb_err;

   modport master (
      output dec_valid, dec_rs_use, dec_rs_idx, dec_rt_use, dec_rt_idx,
             dec_rd_wr, dec_rd_idx, exec_ready, wb_valid, wb_idx, drain_req,
      input  dec_ready, exec_valid, drain_done, reserved, sb_err
   );

   modport slave (
      input  dec_valid, dec_rs_use, dec_rs_idx, dec_rt_use, dec_rt_idx,
             dec_rd_wr, dec_rd_idx, exec_ready, wb_valid, wb_idx, drain_req,
      output dec_ready, exec_valid, drain_done, reserved, sb_err
   );

endinterface

`default_nettype wire

// File: rtl/issue_sched_pend_cnt.sv
//------------------------------------------------------------------------------
// Module   : pend_cnt
// Desc     : Saturating pending-write counter for one architectural register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pend_cnt
   import venus_sched_pkg::*;
#(
   parameter int MAX_PEND_P = MAX_PEND,
   parameter int CNT_W_P    = CNT_W
) (
   input  wire logic               clk,
   input  wire logic               rst,
   input  wire logic               inc,
   input  wire logic               dec,
   output logic     [CNT_W_P-1:0]  count,
   output logic                    nz,
   output logic                    full,
   output logic                    underflow
);

   logic [CNT_W_P-1:0] r_count;
   logic               w_inc_eff;
   logic               w_dec_eff;

   assign nz        = (r_count != '0);
   assign full      = (r_count == CNT_W_P'(MAX_PEND_P));
   assign underflow = dec & ~nz;
   assign count     = r_count;

   // A writeback to an idle register is dropped; a simultaneous inc+dec nets out.
   assign w_dec_eff = dec & nz;
   assign w_inc_eff = inc & (~full | w_dec_eff);

   always_ff @(posedge clk) begin
      if (!rst)
         r_count <= '0;
      else if (w_inc_eff && !w_dec_eff)
         r_count <= r_count + 1'b1;
      else if (w_dec_eff && !w_inc_eff)
         r_count <= r_count - 1'b1;
   end

endmodule

`default_nettype wire

// File: rtl/issue_sched.sv
//------------------------------------------------------------------------------
// Module   : issue_sched
// Desc     : Decode-to-exec issue scheduler with RAW/WAW scoreboard and drain.
//            Optional ISSUE_SCHED_WB_BYPASS_EN lets a same-cycle writeback clear
//            a source hazard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module issue_sched
   import venus_sched_pkg::*;
#(
   parameter int NREG_P     = NREG,
   parameter int IDX_W_P    = IDX_W,
   parameter int MAX_PEND_P = MAX_PEND,
   parameter int CNT_W_P    = CNT_W
) (
   input wire logic     clk,
   input wire logic     rst,
   issue_sched_if.slave bus
);

   sched_state_e        r_state;
   sched_state_e        w_state_nxt;
   logic                r_sb_err;
   logic [NREG_P-1:0]   w_nz;
   logic [NREG_P-1:0]   w_full;
   logic [NREG_P-1:0]   w_underflow;
   logic [NREG_P-1:0]   w_inc;
   logic [NREG_P-1:0]   w_dec;
   logic [NREG_P-1:0]   w_busy;
   logic [CNT_W_P-1:0]  w_count [NREG_P];
   logic                w_all_idle;
   logic                w_raw;
   logic                w_waw_full;
   logic                w_issue;

   genvar gi;
   generate
      for (gi = 0; gi < NREG_P; gi++) begin : g_cnt
         assign w_inc[gi] = w_issue & bus.dec_rd_wr & (bus.dec_rd_idx == IDX_W_P'(gi));
         assign w_dec[gi] = bus.wb_valid & (bus.wb_idx == IDX_W_P'(gi));

         pend_cnt #(
            .MAX_PEND_P (MAX_PEND_P),
            .CNT_W_P    (CNT_W_P)
         ) u_pend_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (w_inc[gi]),
            .dec       (w_dec[gi]),
            .count     (w_count[gi]),
            .nz        (w_nz[gi]),
            .full      (w_full[gi]),
            .underflow (w_underflow[gi])
         );
      end
   endgenerate

   always_comb begin
      w_busy     = w_nz;
      w_all_idle = 1'b1;
      for (int i = 0; i < NREG_P; i++) begin
         if (w_count[i] != '0)
            w_all_idle = 1'b0;
`ifdef ISSUE_SCHED_WB_BYPASS_EN
         // The last outstanding write lands this cycle via register-file write-through.
         if (bus.wb_valid && (bus.wb_idx == IDX_W_P'(i)) && (w_count[i] == CNT_W_P'(1)))
            w_busy[i] = 1'b0;
`endif
      end
   end

   assign w_raw      = (bus.dec_rs_use & w_busy[bus.dec_rs_idx]) |
                       (bus.dec_rt_use & w_busy[bus.dec_rt_idx]);
   assign w_waw_full = bus.dec_rd_wr & w_full[bus.dec_rd_idx];
   // Gating with rst keeps the handshake quiet while reset is asserted.
   assign w_issue    = rst & bus.dec_valid & bus.exec_ready & ~w_raw & ~w_waw_full &
                       (r_state == ST_RUN);

   assign bus.dec_ready  = w_issue;
   assign bus.exec_valid = w_issue;
   assign bus.drain_done = rst & (r_state == ST_DONE);
   assign bus.reserved   = w_nz;
   assign bus.sb_err     = r_sb_err;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= ST_RUN;
         r_sb_err <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_sb_err <= r_sb_err | (|w_underflow);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN:   if (bus.drain_req) w_state_nxt = ST_DRAIN;
         ST_DRAIN: if (w_all_idle)    w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = bus.drain_req ? ST_HOLD : ST_RUN;
         ST_HOLD:  if (!bus.drain_req) w_state_nxt = ST_RUN;
         default:  w_state_nxt = ST_RUN;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_issue_sched.sv
//------------------------------------------------------------------------------
// Module   : tb_issue_sched
// Desc     : Directed self-checking bench for issue_sched.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_issue_sched;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   issue_sched_if bus ();

   issue_sched u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      bus.dec_valid  = 1'b0;
      bus.dec_rs_use = 1'b0;
      bus.dec_rs_idx = '0;
      bus.dec_rt_use = 1'b0;
      bus.dec_rt_idx = '0;
      bus.dec_rd_wr  = 1'b0;
      bus.dec_rd_idx = '0;
      bus.wb_valid   = 1'b0;
      bus.wb_idx     = '0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      clr();
      bus.exec_ready = 1'b1;
      bus.drain_req  = 1'b0;
      rst            = 1'b0;

      // Reset with a pending decode: nothing may be accepted.
      bus.dec_valid = 1'b1;
      tick();
      tick();
      #1;
      chk("rst_reserved",   32'(bus.reserved),   32'h0);
      chk("rst_dec_ready",  32'(bus.dec_ready),  32'h0);
      chk("rst_exec_valid", 32'(bus.exec_valid), 32'h0);
      chk("rst_sb_err",     32'(bus.sb_err),     32'h0);
      chk("rst_drain_done", 32'(bus.drain_done), 32'h0);
      rst = 1'b1;
      bus.dec_valid = 1'b0;
      #1;
      chk("idle_exec_valid", 32'(bus.exec_valid), 32'h0);

      // RAW stall on r1.
      bus.dec_valid = 1'b1; bus.dec_rd_wr = 1'b1; bus.dec_rd_idx = 2'd1;
      #1;
      chk("wr_r1_ready", 32'(bus.dec_ready),  32'h1);
      chk("wr_r1_exec",  32'(bus.exec_valid), 32'h1);
      tick();
      bus.dec_rd_wr = 1'b0; bus.dec_rs_use = 1'b1; bus.dec_rs_idx = 2'd1;
      #1;
      chk("raw_reserved", 32'(bus.reserved),  32'h2);
      chk("raw_stall",    32'(bus.dec_ready), 32'h0);
      tick();
      #1;
      chk("raw_stall_2",  32'(bus.dec_ready), 32'h0);
      bus.wb_valid = 1'b1; bus.wb_idx = 2'd1;
      #1;
`ifdef ISSUE_SCHED_WB_BYPASS_EN
      chk("raw_wb_cycle", 32'(bus.dec_ready), 32'h1);
      tick();
      clr();
`else
      chk("raw_wb_cycle", 32'(bus.dec_ready), 32'h0);
      tick();
      bus.wb_valid = 1'b0;
      #1;
      chk("raw_after_wb", 32'(bus.dec_ready), 32'h1);
      tick();
      clr();
`endif
      #1;
      chk("raw_released", 32'(bus.reserved), 32'h0);

      // Saturation of r2.
      bus.dec_valid = 1'b1; bus.dec_rd_wr = 1'b1; bus.dec_rd_idx = 2'd2;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("sat_fill", 32'(bus.dec_ready), 32'h1);
         tick();
      end
      #1;
      chk("sat_reserved", 32'(bus.reserved),  32'h4);
      chk("sat_stall",    32'(bus.dec_ready), 32'h0);
      bus.dec_rd_wr = 1'b0; bus.dec_rs_use = 1'b1; bus.dec_rs_idx = 2'd0;
      #1;
      chk("sat_read_r0",  32'(bus.dec_ready), 32'h1);
      bus.dec_rs_use = 1'b0; bus.dec_rd_wr = 1'b1;
      bus.wb_valid = 1'b1; bus.wb_idx = 2'd2;
      #1;
      chk("sat_wb_cycle", 32'(bus.dec_ready), 32'h0);
      tick();
      bus.wb_valid = 1'b0;
      #1;
      chk("sat_after_wb", 32'(bus.dec_ready), 32'h1);
      tick();
      clr();
      bus.wb_valid = 1'b1; bus.wb_idx = 2'd2;
      tick(); tick(); tick();
      bus.wb_valid = 1'b0;
      #1;
      chk("sat_emptied", 32'(bus.reserved), 32'h0);

      // Simultaneous issue-write and writeback on r3.
      bus.dec_valid = 1'b1; bus.dec_rd_wr = 1'b1; bus.dec_rd_idx = 2'd3;
      tick();
      bus.wb_valid = 1'b1; bus.wb_idx = 2'd3;
      #1;
      chk("sim_ready", 32'(bus.dec_ready), 32'h1);
      tick();
      clr();
      #1;
      chk("sim_reserved", 32'(bus.reserved), 32'h8);
      bus.wb_valid = 1'b1; bus.wb_idx = 2'd3;
      tick();
      bus.wb_valid = 1'b0;
      #1;
      chk("sim_one_left", 32'(bus.reserved), 32'h0);

      // Drain with pend[0]=2, then hold and release.
      bus.dec_valid = 1'b1; bus.dec_rd_wr = 1'b1; bus.dec_rd_idx = 2'd0;
      tick(); tick();
      clr();
      bus.drain_req = 1'b1;
      tick();
      bus.dec_valid = 1'b1; bus.dec_rs_use = 1'b1; bus.dec_rs_idx = 2'd1;
      #1;
      chk("drn_block",    32'(bus.dec_ready), 32'h0);
      chk("drn_reserved", 32'(bus.reserved),  32'h1);
      bus.wb_valid = 1'b1; bus.wb_idx = 2'd0;
      tick();
      #1;
      chk("drn_pend1",    32'(bus.drain_done), 32'h0);
      tick();
      bus.wb_valid = 1'b0;
      #1;
      chk("drn_pend0",    32'(bus.drain_done), 32'h0);
      chk("drn_empty",    32'(bus.reserved),   32'h0);
      tick();
      #1;
      chk("drn_done",       32'(bus.drain_done), 32'h1);
      chk("drn_done_block", 32'(bus.dec_ready),  32'h0);
      tick();
      #1;
      chk("drn_pulse_end",  32'(bus.drain_done), 32'h0);
      chk("drn_hold_block", 32'(bus.dec_ready),  32'h0);
      bus.drain_req = 1'b0;
      #1;
      chk("drn_hold_last",  32'(bus.dec_ready),  32'h0);
      tick();
      #1;
      chk("drn_resume",     32'(bus.dec_ready),  32'h1);
      tick();
      clr();

      // Writeback to an idle register sets the sticky error.
      bus.wb_valid = 1'b1; bus.wb_idx = 2'd2;
      #1;
      chk("err_before", 32'(bus.sb_err), 32'h0);
      tick();
      bus.wb_valid = 1'b0;
      #1;
      chk("err_set",      32'(bus.sb_err),   32'h1);
      chk("err_counters", 32'(bus.reserved), 32'h0);
      tick(); tick();
      #1;
      chk("err_sticky",   32'(bus.sb_err),   32'h1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("err_cleared",  32'(bus.sb_err),   32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
